// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs -- reservation station in front of the combinational ALU.
//
// Holds decoded integer/branch/jump ops from dispatch until both source
// operands are known. Pending operands are woken by snooping the ALU (A) and
// LSB (L) CDB channels. At most one ready op per cycle is issued through
// registered outputs. The ROB flushes the station on a misprediction.
//
// Ports
//   clk_in, rst_in (sync, active-low), rdy_in (0 = pause), clear_in (flush)
//   *_dsp_in     : op from dispatch (valid, pc, opcode, operand j/k tag or
//                  value, immediate, destination ROB tag)
//   full_dsp_out : registered back-pressure, asserted at occupancy >= RS_SIZE-1
//   *_a_cdb_in   : ALU broadcast (valid, result, ROB tag)
//   *_l_cdb_in   : LSB broadcast (valid, result, ROB tag)
//   *_alu_out    : issued op; rdy_alu_out pulses for one cycle per op
// ---------------------------------------------------------------------------
module alu_rs #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int OP_WIDTH     = 6,
   parameter int ROB_WIDTH    = 4,
   parameter int RS_SIZE      = 16,
   parameter int RS_IDX_WIDTH = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  clear_in,

   input  logic                  valid_dsp_in,
   input  logic [ADDR_WIDTH-1:0] pc_dsp_in,
   input  logic [OP_WIDTH-1:0]   opcode_dsp_in,
   input  logic                  qj_busy_dsp_in,
   input  logic                  qk_busy_dsp_in,
   input  logic [ROB_WIDTH-1:0]  qj_dsp_in,
   input  logic [ROB_WIDTH-1:0]  qk_dsp_in,
   input  logic [DATA_WIDTH-1:0] vj_dsp_in,
   input  logic [DATA_WIDTH-1:0] vk_dsp_in,
   input  logic [DATA_WIDTH-1:0] imm_dsp_in,
   input  logic [ROB_WIDTH-1:0]  rob_id_dsp_in,
   output logic                  full_dsp_out,

   input  logic                  rdy_a_cdb_in,
   input  logic [DATA_WIDTH-1:0] result_a_cdb_in,
   input  logic [ROB_WIDTH-1:0]  rob_id_a_cdb_in,
   input  logic                  rdy_l_cdb_in,
   input  logic [DATA_WIDTH-1:0] result_l_cdb_in,
   input  logic [ROB_WIDTH-1:0]  rob_id_l_cdb_in,

   output logic                  rdy_alu_out,
   output logic [ADDR_WIDTH-1:0] pc_alu_out,
   output logic [OP_WIDTH-1:0]   opcode_alu_out,
   output logic [DATA_WIDTH-1:0] vj_alu_out,
   output logic [DATA_WIDTH-1:0] vk_alu_out,
   output logic [DATA_WIDTH-1:0] imm_alu_out,
   output logic [ROB_WIDTH-1:0]  rob_id_alu_out
);

   localparam int CNT_WIDTH = RS_IDX_WIDTH + 1;

   typedef struct packed {
      logic                  busy;
      logic [ADDR_WIDTH-1:0] pc;
      logic [OP_WIDTH-1:0]   opcode;
      logic                  qj_busy;
      logic                  qk_busy;
      logic [ROB_WIDTH-1:0]  qj;
      logic [ROB_WIDTH-1:0]  qk;
      logic [DATA_WIDTH-1:0] vj;
      logic [DATA_WIDTH-1:0] vk;
      logic [DATA_WIDTH-1:0] imm;
      logic [ROB_WIDTH-1:0]  rob_id;
   } entry_t;

   entry_t                  rs_q [RS_SIZE];

   logic                    issue_found;
   logic [RS_IDX_WIDTH-1:0] issue_idx;
   logic                    free_found;
   logic [RS_IDX_WIDTH-1:0] free_idx;
   logic [CNT_WIDTH-1:0]    occ_count;
   logic [CNT_WIDTH-1:0]    occ_next;
   logic                    alloc;
   logic [DATA_WIDTH:0]     j_snoop;
   logic [DATA_WIDTH:0]     k_snoop;
   entry_t                  new_entry;

   // Resolve one operand against both CDB channels. Returns
   // {still_pending, value}. The ROB never puts the same tag on both
   // channels, so the A-over-L ordering here is arbitrary.
   function automatic logic [DATA_WIDTH:0] snoop(
      input logic                  pending,
      input logic [ROB_WIDTH-1:0]  tag,
      input logic [DATA_WIDTH-1:0] value
   );
      if (pending && rdy_a_cdb_in && tag == rob_id_a_cdb_in)
         return {1'b0, result_a_cdb_in};
      else if (pending && rdy_l_cdb_in && tag == rob_id_l_cdb_in)
         return {1'b0, result_l_cdb_in};
      else
         return {pending, value};
   endfunction

   // Priority pick of the lowest-index ready entry and the lowest-index free
   // entry, both from pre-edge state, plus the current occupancy. Scanning
   // from the top down lets the last hit be the lowest index.
   // NOTE: every variable gets a default before the loop so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      issue_found = 1'b0;
      issue_idx   = '0;
      free_found  = 1'b0;
      free_idx    = '0;
      occ_count   = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (rs_q[i].busy && !rs_q[i].qj_busy && !rs_q[i].qk_busy) begin
            issue_found = 1'b1;
            issue_idx   = RS_IDX_WIDTH'(i);
         end
         if (!rs_q[i].busy) begin
            free_found = 1'b1;
            free_idx   = RS_IDX_WIDTH'(i);
         end
         occ_count = occ_count + CNT_WIDTH'(rs_q[i].busy);
      end
   end

   assign alloc    = valid_dsp_in && free_found;
   assign occ_next = occ_count - CNT_WIDTH'(issue_found) + CNT_WIDTH'(alloc);

   // Incoming op with dispatch-time bypass from a same-cycle broadcast.
   always_comb begin
      j_snoop           = snoop(qj_busy_dsp_in, qj_dsp_in, vj_dsp_in);
      k_snoop           = snoop(qk_busy_dsp_in, qk_dsp_in, vk_dsp_in);
      new_entry         = '0;
      new_entry.busy    = 1'b1;
      new_entry.pc      = pc_dsp_in;
      new_entry.opcode  = opcode_dsp_in;
      new_entry.qj_busy = j_snoop[DATA_WIDTH];
      new_entry.qk_busy = k_snoop[DATA_WIDTH];
      new_entry.qj      = qj_dsp_in;
      new_entry.qk      = qk_dsp_in;
      new_entry.vj      = j_snoop[DATA_WIDTH-1:0];
      new_entry.vk      = k_snoop[DATA_WIDTH-1:0];
      new_entry.imm     = imm_dsp_in;
      new_entry.rob_id  = rob_id_dsp_in;
   end

   // NOTE: all state updates use non-blocking assignments so that issue,
   // wakeup and allocation all see the same pre-edge entry contents.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         // NOTE: only the busy bits are reset; payload fields of a non-busy
         // entry are never observed, so the storage array needs no reset.
         for (int i = 0; i < RS_SIZE; i++) rs_q[i].busy <= 1'b0;
         rdy_alu_out    <= 1'b0;
         full_dsp_out   <= 1'b0;
         pc_alu_out     <= '0;
         opcode_alu_out <= '0;
         vj_alu_out     <= '0;
         vk_alu_out     <= '0;
         imm_alu_out    <= '0;
         rob_id_alu_out <= '0;
      end else if (clear_in) begin
         for (int i = 0; i < RS_SIZE; i++) rs_q[i].busy <= 1'b0;
         rdy_alu_out  <= 1'b0;
         full_dsp_out <= 1'b0;
      end else if (!rdy_in) begin
         rdy_alu_out <= 1'b0;
      end else begin
         // Wakeup touches only operand fields of occupied entries.
         for (int i = 0; i < RS_SIZE; i++) begin
            if (rs_q[i].busy) begin
               {rs_q[i].qj_busy, rs_q[i].vj} <= snoop(rs_q[i].qj_busy, rs_q[i].qj, rs_q[i].vj);
               {rs_q[i].qk_busy, rs_q[i].vk} <= snoop(rs_q[i].qk_busy, rs_q[i].qk, rs_q[i].vk);
            end
         end

         rdy_alu_out <= issue_found;
         if (issue_found) begin
            pc_alu_out              <= rs_q[issue_idx].pc;
            opcode_alu_out          <= rs_q[issue_idx].opcode;
            vj_alu_out              <= rs_q[issue_idx].vj;
            vk_alu_out              <= rs_q[issue_idx].vk;
            imm_alu_out             <= rs_q[issue_idx].imm;
            rob_id_alu_out          <= rs_q[issue_idx].rob_id;
            rs_q[issue_idx].busy    <= 1'b0;
         end

         // The free slot is chosen from pre-edge state, so it can never be
         // the entry issuing at this same edge.
         if (alloc) rs_q[free_idx] <= new_entry;

`ifdef DEBUG
         if (valid_dsp_in && !free_found)
            $display("alu_rs: dispatch into full station dropped (rob_id %0d)", rob_id_dsp_in);
`endif

         full_dsp_out <= (occ_next >= CNT_WIDTH'(RS_SIZE - 1));
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// ---------------------------------------------------------------------------
// tb_alu_rs -- self-checking bench for alu_rs.
// A directed table covers single-op latency, CDB wakeup and dispatch bypass;
// hand-written sequences cover fill/drain, flush, mid-stream reset and pause;
// a randomized phase compares every output each cycle against a reference
// model of the station kept here.
// ---------------------------------------------------------------------------
module tb_alu_rs;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear_in;
   logic        valid_dsp_in;
   logic [31:0] pc_dsp_in;
   logic [5:0]  opcode_dsp_in;
   logic        qj_busy_dsp_in, qk_busy_dsp_in;
   logic [3:0]  qj_dsp_in, qk_dsp_in;
   logic [31:0] vj_dsp_in, vk_dsp_in, imm_dsp_in;
   logic [3:0]  rob_id_dsp_in;
   logic        full_dsp_out;
   logic        rdy_a_cdb_in, rdy_l_cdb_in;
   logic [31:0] result_a_cdb_in, result_l_cdb_in;
   logic [3:0]  rob_id_a_cdb_in, rob_id_l_cdb_in;
   logic        rdy_alu_out;
   logic [31:0] pc_alu_out;
   logic [5:0]  opcode_alu_out;
   logic [31:0] vj_alu_out, vk_alu_out, imm_alu_out;
   logic [3:0]  rob_id_alu_out;

   always #5 clk_in = ~clk_in;

   alu_rs dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
      .valid_dsp_in(valid_dsp_in), .pc_dsp_in(pc_dsp_in), .opcode_dsp_in(opcode_dsp_in),
      .qj_busy_dsp_in(qj_busy_dsp_in), .qk_busy_dsp_in(qk_busy_dsp_in),
      .qj_dsp_in(qj_dsp_in), .qk_dsp_in(qk_dsp_in),
      .vj_dsp_in(vj_dsp_in), .vk_dsp_in(vk_dsp_in), .imm_dsp_in(imm_dsp_in),
      .rob_id_dsp_in(rob_id_dsp_in), .full_dsp_out(full_dsp_out),
      .rdy_a_cdb_in(rdy_a_cdb_in), .result_a_cdb_in(result_a_cdb_in), .rob_id_a_cdb_in(rob_id_a_cdb_in),
      .rdy_l_cdb_in(rdy_l_cdb_in), .result_l_cdb_in(result_l_cdb_in), .rob_id_l_cdb_in(rob_id_l_cdb_in),
      .rdy_alu_out(rdy_alu_out), .pc_alu_out(pc_alu_out), .opcode_alu_out(opcode_alu_out),
      .vj_alu_out(vj_alu_out), .vk_alu_out(vk_alu_out), .imm_alu_out(imm_alu_out),
      .rob_id_alu_out(rob_id_alu_out)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit          busy;
      bit          jp, kp;
      logic [3:0]  jt, kt;
      logic [31:0] pc, vj, vk, imm;
      logic [5:0]  op;
      logic [3:0]  rob;
   } m_ent_t;

   m_ent_t      m [16];
   bit          e_rdy, e_full;
   logic [31:0] e_pc, e_vj, e_vk, e_imm;
   logic [5:0]  e_op;
   logic [3:0]  e_rob;

   // An operand waiting on a tag takes the value of whichever channel
   // broadcasts that tag this cycle.
   function automatic void resolve(input bit p, input logic [3:0] t, input logic [31:0] v,
                                   output bit po, output logic [31:0] vo);
      po = p; vo = v;
      if (p && rdy_a_cdb_in && t == rob_id_a_cdb_in) begin po = 0; vo = result_a_cdb_in; end
      else if (p && rdy_l_cdb_in && t == rob_id_l_cdb_in) begin po = 0; vo = result_l_cdb_in; end
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   function automatic void model_edge();
      m_ent_t nxt [16];
      int     iss, fre, cnt;
      if (!rst_in) begin
         foreach (m[i]) m[i].busy = 0;
         e_rdy = 0; e_full = 0;
         e_pc = 0; e_op = 0; e_vj = 0; e_vk = 0; e_imm = 0; e_rob = 0;
         return;
      end
      if (clear_in) begin
         foreach (m[i]) m[i].busy = 0;
         e_rdy = 0; e_full = 0;
         return;
      end
      if (!rdy_in) begin
         e_rdy = 0;
         return;
      end
      nxt = m;
      iss = -1; fre = -1;
      for (int i = 15; i >= 0; i--) begin
         if (m[i].busy && !m[i].jp && !m[i].kp) iss = i;
         if (!m[i].busy) fre = i;
      end
      for (int i = 0; i < 16; i++)
         if (m[i].busy) begin
            resolve(m[i].jp, m[i].jt, m[i].vj, nxt[i].jp, nxt[i].vj);
            resolve(m[i].kp, m[i].kt, m[i].vk, nxt[i].kp, nxt[i].vk);
         end
      e_rdy = (iss >= 0);
      if (iss >= 0) begin
         e_pc = m[iss].pc; e_op = m[iss].op; e_vj = m[iss].vj; e_vk = m[iss].vk;
         e_imm = m[iss].imm; e_rob = m[iss].rob;
         nxt[iss].busy = 0;
      end
      if (valid_dsp_in && fre >= 0) begin
         nxt[fre].busy = 1;
         nxt[fre].pc = pc_dsp_in; nxt[fre].op = opcode_dsp_in;
         nxt[fre].imm = imm_dsp_in; nxt[fre].rob = rob_id_dsp_in;
         nxt[fre].jt = qj_dsp_in; nxt[fre].kt = qk_dsp_in;
         resolve(qj_busy_dsp_in, qj_dsp_in, vj_dsp_in, nxt[fre].jp, nxt[fre].vj);
         resolve(qk_busy_dsp_in, qk_dsp_in, vk_dsp_in, nxt[fre].kp, nxt[fre].vk);
      end
      cnt = 0;
      foreach (nxt[i]) cnt += int'(nxt[i].busy);
      e_full = (cnt >= 15);
      m = nxt;
   endfunction

   // ---------------- drivers ----------------
   task automatic idle();
      rst_in = 1; rdy_in = 1; clear_in = 0; valid_dsp_in = 0;
      pc_dsp_in = 0; opcode_dsp_in = 0; qj_busy_dsp_in = 0; qk_busy_dsp_in = 0;
      qj_dsp_in = 0; qk_dsp_in = 0; vj_dsp_in = 0; vk_dsp_in = 0; imm_dsp_in = 0;
      rob_id_dsp_in = 0;
      rdy_a_cdb_in = 0; result_a_cdb_in = 0; rob_id_a_cdb_in = 0;
      rdy_l_cdb_in = 0; result_l_cdb_in = 0; rob_id_l_cdb_in = 0;
   endtask

   task automatic dispatch(input logic [5:0] op, input logic [31:0] pc,
                           input bit jb, input logic [3:0] jt, input logic [31:0] vj,
                           input bit kb, input logic [3:0] kt, input logic [31:0] vk,
                           input logic [3:0] rob);
      valid_dsp_in = 1; opcode_dsp_in = op; pc_dsp_in = pc; imm_dsp_in = pc ^ 32'h5a5a;
      qj_busy_dsp_in = jb; qj_dsp_in = jt; vj_dsp_in = vj;
      qk_busy_dsp_in = kb; qk_dsp_in = kt; vk_dsp_in = vk;
      rob_id_dsp_in = rob;
   endtask

   // One clock edge: update model, let the DUT clock, sample 1 ns later and
   // compare every output to the model.
   task automatic step();
      model_edge();
      @(posedge clk_in);
      #1;
      check("model_rdy", rdy_alu_out, e_rdy);
      check("model_full", full_dsp_out, e_full);
      check("model_pc", pc_alu_out, e_pc);
      check("model_op", opcode_alu_out, e_op);
      check("model_vj", vj_alu_out, e_vj);
      check("model_vk", vk_alu_out, e_vk);
      check("model_imm", imm_alu_out, e_imm);
      check("model_rob", rob_id_alu_out, e_rob);
   endtask

   task automatic do_reset();
      idle(); rst_in = 0;
      step();
      check("reset_rdy", rdy_alu_out, 0);
      check("reset_full", full_dsp_out, 0);
      check("reset_vj", vj_alu_out, 0);
      idle();
   endtask

   // ---------------- directed table ----------------
   typedef struct packed {
      logic        valid;
      logic [5:0]  op;
      logic        jb;
      logic [3:0]  jt;
      logic [31:0] vj;
      logic        kb;
      logic [3:0]  kt;
      logic [31:0] vk;
      logic [3:0]  rob;
      logic        ca, cl;
      logic [3:0]  ctag;
      logic [31:0] cres;
      logic        e_rdy;
      logic [31:0] e_vj, e_vk;
      logic [3:0]  e_rob;
   } vec_t;

   vec_t tbl [13];

   initial begin
      bit seen;
      // ADD, both ready: issue after the following edge, then quiet.
      tbl[0]  = '{1, 1, 0, 0, 5, 0, 0, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 7, 3};
      tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      // SUB waiting on tag 2; unrelated L broadcast (tag 5) does nothing.
      tbl[3]  = '{1, 2, 1, 2, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h55, 0, 0, 0, 0};
      tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 32'h10, 0, 0, 0, 0};
      tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 1, 4};
      tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      // Dispatch-time bypass of operand k from the L channel.
      tbl[9]  = '{1, 3, 0, 0, 2, 1, 6, 0, 7, 0, 1, 6, 32'hAB, 0, 0, 0, 0};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'hAB, 7};
      tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

      idle();
      do_reset();

      for (int i = 0; i < 13; i++) begin
         idle();
         if (tbl[i].valid)
            dispatch(tbl[i].op, 32'h100 + i, tbl[i].jb, tbl[i].jt, tbl[i].vj,
                     tbl[i].kb, tbl[i].kt, tbl[i].vk, tbl[i].rob);
         rdy_a_cdb_in = tbl[i].ca; rdy_l_cdb_in = tbl[i].cl;
         rob_id_a_cdb_in = tbl[i].ctag; rob_id_l_cdb_in = tbl[i].ctag;
         result_a_cdb_in = tbl[i].cres; result_l_cdb_in = tbl[i].cres;
         step();
         check($sformatf("tbl%0d_rdy", i), rdy_alu_out, tbl[i].e_rdy);
         if (tbl[i].e_rdy) begin
            check($sformatf("tbl%0d_vj", i), vj_alu_out, tbl[i].e_vj);
            check($sformatf("tbl%0d_vk", i), vk_alu_out, tbl[i].e_vk);
            check($sformatf("tbl%0d_rob", i), rob_id_alu_out, tbl[i].e_rob);
         end
      end

      // ---------------- fill all 16 entries, then drain ----------------
      do_reset();
      for (int i = 0; i < 16; i++) begin
         idle();
         dispatch(6'd4, i, 1, 4'd9, 0, 0, 0, i, 4'(i));
         step();
         check($sformatf("fill%0d_full", i), full_dsp_out, (i >= 14) ? 1 : 0);
      end
      idle();
      rdy_a_cdb_in = 1; rob_id_a_cdb_in = 9; result_a_cdb_in = 32'h99;
      step();
      check("bcast9_rdy", rdy_alu_out, 0);
      idle();
      for (int k = 0; k < 16; k++) begin
         step();
         check($sformatf("drain%0d_rdy", k), rdy_alu_out, 1);
         check($sformatf("drain%0d_idx", k), pc_alu_out, k);
         check($sformatf("drain%0d_vj", k), vj_alu_out, 32'h99);
         check($sformatf("drain%0d_full", k), full_dsp_out, (k == 0) ? 1 : 0);
      end
      step();
      check("drain_end_rdy", rdy_alu_out, 0);

      // ---------------- flush and mid-stream reset ----------------
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         for (int i = 0; i < 4; i++) begin
            idle();
            dispatch(6'd5, 32'h200 + i, 1, 4'd1, 0, 0, 0, 3, 4'(i));
            step();
         end
         idle();
         dispatch(6'd6, 32'h300, 0, 0, 8, 0, 0, 9, 4'd12);
         if (pass == 0) clear_in = 1; else rst_in = 0;
         step();
         check($sformatf("flush%0d_rdy", pass), rdy_alu_out, 0);
         check($sformatf("flush%0d_full", pass), full_dsp_out, 0);
         idle();
         rdy_a_cdb_in = 1; rob_id_a_cdb_in = 1; result_a_cdb_in = 32'h77;
         step();
         idle();
         seen = 0;
         for (int c = 0; c < 10; c++) begin
            step();
            if (rdy_alu_out !== 1'b0) seen = 1;
         end
         check($sformatf("flush%0d_no_issue", pass), 32'(seen), 0);
      end

      // ---------------- pause with rdy_in = 0 ----------------
      do_reset();
      dispatch(6'd7, 32'h400, 0, 0, 1, 1, 4'd4, 0, 4'd2);   // waits on tag 4
      step();
      idle();
      dispatch(6'd8, 32'h404, 0, 0, 11, 0, 0, 12, 4'd1);    // ready
      step();
      for (int c = 0; c < 3; c++) begin
         idle(); rdy_in = 0;
         rdy_a_cdb_in = 1; rob_id_a_cdb_in = 4; result_a_cdb_in = 32'h44;
         step();
         check($sformatf("pause%0d_rdy", c), rdy_alu_out, 0);
      end
      idle();
      step();
      check("resume_rdy", rdy_alu_out, 1);
      check("resume_rob", rob_id_alu_out, 1);
      step();
      check("resume_no_capture", rdy_alu_out, 0);
      rdy_a_cdb_in = 1; rob_id_a_cdb_in = 4; result_a_cdb_in = 32'h45;
      step();
      idle();
      step();
      check("late_wake_rdy", rdy_alu_out, 1);
      check("late_wake_vk", vk_alu_out, 32'h45);

      // ---------------- randomized run against the model ----------------
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         idle();
         rdy_in   = ($urandom_range(0, 9) != 0);
         clear_in = ($urandom_range(0, 149) == 0);
         rst_in   = ($urandom_range(0, 299) != 0);
         if (!e_full && $urandom_range(0, 9) < 6)
            dispatch(6'($urandom), $urandom, 1'($urandom), 4'($urandom_range(0, 7)), $urandom,
                     1'($urandom), 4'($urandom_range(0, 7)), $urandom, 4'($urandom));
         if ($urandom_range(0, 9) < 3) begin
            rdy_a_cdb_in = 1; rob_id_a_cdb_in = 4'($urandom_range(0, 7)); result_a_cdb_in = $urandom;
         end
         if ($urandom_range(0, 9) < 3) begin
            rdy_l_cdb_in = 1; rob_id_l_cdb_in = 4'($urandom_range(0, 7)); result_l_cdb_in = $urandom;
            if (rdy_a_cdb_in && rob_id_l_cdb_in == rob_id_a_cdb_in)
               rob_id_l_cdb_in = rob_id_a_cdb_in ^ 4'd8;
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
